// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI mode-0 transfer engine between the SPI_CNT register and TX/RX RAMs.
// Build option: define SPI_WAIT_TOKEN_EN for wait-token mode and its timeout counter.
module spi_xfer_sequencer #(
    parameter int SLOW_HALF     = 16,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic        FastClk,
    input  logic        nReset,
    input  logic        CntWrite,
    input  logic [15:0] CntData,
    output logic [15:0] Status,
    output logic        Busy,
    output logic        Done,
    output logic [8:0]  TXAddr,
    input  logic [7:0]  TXData,
    output logic [8:0]  RXAddr,
    output logic [7:0]  RXData,
    output logic        RXWrite,
    output logic        SPI_Clk,
    output logic        SPI_Do,
    input  logic        SPI_Di,
    output logic        SPI_Cs
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT, S_STORE, S_DONE
    } state_t;

    localparam int DW = $clog2(SLOW_HALF);
    localparam int TW = $clog2(TOKEN_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [8:0]    len_q, idx_q;
    logic [1:0]    mode_q;
    logic          slow_q, cs_q;
    logic [2:0]    bit_q;
    logic          phase_q, fresh_q;
    logic [DW-1:0] div_q;
    logic [7:0]    tx_q, rx_q;
    logic [7:0]    tx_sel, tx_cur;
    logic          load, start, half_end, last_byte;
    logic          discard, expire, tmo;
    logic          unused_bits;

    assign load      = CntWrite && (state_q == S_IDLE);
    assign start     = load && CntData[15];
    assign half_end  = !slow_q || (div_q == DW'(SLOW_HALF - 1));
    assign last_byte = (idx_q == len_q);
    assign tx_sel    = mode_q[1] ? 8'hFF : TXData;
    // TX RAM data only lands in the first shift cycle, so bypass the latch then
    assign tx_cur    = fresh_q ? tx_sel : tx_q;
    assign unused_bits = ^CntData[13:12];

`ifdef SPI_WAIT_TOKEN_EN
    logic          tok_q, tmo_q;
    logic [TW-1:0] tcnt_q;

    assign discard = (mode_q == 2'b11) && !tok_q && (rx_q == 8'hFF);
    assign expire  = discard && (tcnt_q == TW'(TOKEN_TIMEOUT - 1));
    assign tmo     = tmo_q;

    always_ff @(posedge FastClk) begin
        if (!nReset) begin
            tok_q  <= 1'b0;
            tmo_q  <= 1'b0;
            tcnt_q <= '0;
        end else begin
            if (load) tmo_q <= 1'b0;
            if (start) begin
                tok_q  <= 1'b0;
                tcnt_q <= '0;
            end
            if (state_q == S_STORE) begin
                if (expire) tmo_q <= 1'b1;
                else if (discard) tcnt_q <= tcnt_q + TW'(1);
                else tok_q <= 1'b1;
            end
        end
    end
`else
    assign discard = 1'b0;
    assign expire  = 1'b0;
    assign tmo     = 1'b0;
`endif

    always_ff @(posedge FastClk) begin
        if (!nReset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_SHIFT;
            S_SHIFT: if (half_end && phase_q && bit_q == 3'd0) state_d = S_STORE;
            S_STORE: begin
                if (expire) state_d = S_DONE;
                else if (discard) state_d = S_FETCH;
                else if (last_byte) state_d = S_DONE;
                else state_d = S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = 1'b0;
        Done    = 1'b0;
        RXWrite = 1'b0;
        SPI_Clk = 1'b0;
        SPI_Do  = 1'b1;
        unique case (state_q)
            S_FETCH: Busy = 1'b1;
            S_SHIFT: begin
                Busy    = 1'b1;
                SPI_Clk = phase_q;
                SPI_Do  = tx_cur[bit_q];
            end
            S_STORE: begin
                Busy    = 1'b1;
                RXWrite = (mode_q != 2'b01) && !discard;
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge FastClk) begin
        if (!nReset) begin
            len_q   <= '0;
            mode_q  <= '0;
            slow_q  <= 1'b0;
            cs_q    <= 1'b0;
            idx_q   <= '0;
            bit_q   <= 3'd7;
            phase_q <= 1'b0;
            fresh_q <= 1'b0;
            div_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            if (load) begin
                len_q  <= CntData[8:0];
                mode_q <= CntData[10:9];
                slow_q <= CntData[11];
                cs_q   <= CntData[14];
            end
            if (start) idx_q <= '0;
            if (state_q == S_FETCH) begin
                fresh_q <= 1'b1;
                bit_q   <= 3'd7;
                phase_q <= 1'b0;
                div_q   <= '0;
            end
            if (state_q == S_SHIFT) begin
                fresh_q <= 1'b0;
                if (fresh_q) tx_q <= tx_sel;
                // MISO is taken on the first cycle of the high phase
                if (phase_q && div_q == '0) rx_q <= {rx_q[6:0], SPI_Di};
                if (half_end) begin
                    div_q   <= '0;
                    phase_q <= !phase_q;
                    if (phase_q) bit_q <= bit_q - 3'd1;
                end else begin
                    div_q <= div_q + DW'(1);
                end
            end
            if (state_q == S_STORE && !discard && !last_byte)
                idx_q <= idx_q + 9'd1;
        end
    end

    assign Status = {Busy, cs_q, 1'b0, tmo, slow_q, mode_q, len_q};
    assign TXAddr = idx_q;
    assign RXAddr = idx_q;
    assign RXData = rx_q;
    assign SPI_Cs = !cs_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer: RX writes and MOSI bytes checked against queues.
module tb_spi_xfer_sequencer;
    logic        FastClk, nReset, CntWrite;
    logic [15:0] CntData, Status;
    logic        Busy, Done, RXWrite;
    logic [8:0]  TXAddr, RXAddr;
    logic [7:0]  TXData, RXData;
    logic        SPI_Clk, SPI_Do, SPI_Di, SPI_Cs;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  tx_mem [512];
    logic [16:0] rxq [$];
    logic [7:0]  mq [$];
    logic [7:0]  sq [$];
    logic [7:0]  sb = 8'hFF;
    logic [2:0]  sbit = 3'd7;
    logic [7:0]  msh = 8'h00;
    int          mbits = 0;

    int r_cyc, r_busy, r_clk1, r_hi, r_per, r_maxa, r_csbad;

    spi_xfer_sequencer dut (
        .FastClk (FastClk),
        .nReset  (nReset),
        .CntWrite(CntWrite),
        .CntData (CntData),
        .Status  (Status),
        .Busy    (Busy),
        .Done    (Done),
        .TXAddr  (TXAddr),
        .TXData  (TXData),
        .RXAddr  (RXAddr),
        .RXData  (RXData),
        .RXWrite (RXWrite),
        .SPI_Clk (SPI_Clk),
        .SPI_Do  (SPI_Do),
        .SPI_Di  (SPI_Di),
        .SPI_Cs  (SPI_Cs)
    );

    initial FastClk = 1'b0;
    always #5 FastClk = ~FastClk;

    always @(posedge FastClk) TXData <= tx_mem[TXAddr];

    // slave: presents the current bit, advances after each falling SPI_Clk
    assign SPI_Di = sb[sbit];
    always begin
        @(negedge SPI_Clk);
        #2;
        if (sbit == 3'd0) begin
            sb = (sq.size() != 0) ? sq.pop_front() : 8'hFF;
            sbit = 3'd7;
        end else begin
            sbit = sbit - 3'd1;
        end
    end

    always begin
        @(posedge FastClk);
        #1;
        if (RXWrite) begin
            logic [16:0] e;
            vectors++;
            if (rxq.size() == 0) begin
                miscompares++;
                $display("FAIL rxwrite_unexpected: addr %h data %h, none required",
                         RXAddr, RXData);
            end else begin
                e = rxq.pop_front();
                if ({RXAddr, RXData} !== e) begin
                    miscompares++;
                    $display("FAIL rxwrite: got addr %h data %h, required addr %h data %h",
                             RXAddr, RXData, e[16:8], e[7:0]);
                end
            end
        end
    end

    always begin
        @(posedge SPI_Clk);
        #1;
        msh = {msh[6:0], SPI_Do};
        mbits++;
        if (mbits == 8) begin
            logic [7:0] e;
            mbits = 0;
            vectors++;
            if (mq.size() == 0) begin
                miscompares++;
                $display("FAIL mosi_unexpected: got %h, none required", msh);
            end else begin
                e = mq.pop_front();
                if (msh !== e) begin
                    miscompares++;
                    $display("FAIL mosi: got %h required %h", msh, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic prime();
        sb = (sq.size() != 0) ? sq.pop_front() : 8'hFF;
        sbit = 3'd7;
    endtask

    task automatic run(input logic [15:0] d, input int maxc, input int poke);
        int hi_run;
        int rise_n;
        logic prev_clk;
        r_cyc = 0; r_busy = 0; r_clk1 = -1; r_hi = -1; r_per = -1;
        r_maxa = 0; r_csbad = 0; hi_run = 0; rise_n = 0; prev_clk = 1'b0;
        CntData = d;
        CntWrite = 1'b1;
        @(posedge FastClk);
        #1;
        CntWrite = 1'b0;
        while (!Done && r_cyc < maxc) begin
            if (Busy) r_busy++;
            if (int'(TXAddr) > r_maxa) r_maxa = int'(TXAddr);
            if (SPI_Cs !== 1'b0) r_csbad++;
            if (SPI_Clk && !prev_clk) begin
                rise_n++;
                if (rise_n == 1) r_clk1 = r_cyc + 1;
                else if (rise_n == 2) r_per = r_cyc + 1 - r_clk1;
            end
            if (SPI_Clk) hi_run++;
            if (!SPI_Clk && prev_clk && r_hi < 0) r_hi = hi_run;
            prev_clk = SPI_Clk;
            if (r_cyc == poke) begin
                CntData = 16'h0000;
                CntWrite = 1'b1;
            end else begin
                CntWrite = 1'b0;
            end
            @(posedge FastClk);
            #1;
            r_cyc++;
        end
        CntWrite = 1'b0;
        vectors++;
        if (!Done) begin
            miscompares++;
            $display("FAIL done_timeout: no Done after %0d cycles, required within %0d",
                     r_cyc, maxc);
        end
        @(posedge FastClk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0;
        CntWrite = 1'b0;
        CntData = 16'h0000;
        for (int i = 0; i < 512; i++) tx_mem[i] = 8'h00;
        repeat (2) @(posedge FastClk);
        #1;
        chk("reset_cs", SPI_Cs, 1);
        chk("reset_do", SPI_Do, 1);
        chk("reset_clk", SPI_Clk, 0);
        chk("reset_status", Status, 16'h0000);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_rxwrite", RXWrite, 0);
        nReset = 1'b1;
        @(posedge FastClk);
        #1;

        // exchange, 4 bytes, slave returns inverted bytes
        tx_mem[0] = 8'hA5; tx_mem[1] = 8'h3C; tx_mem[2] = 8'h00; tx_mem[3] = 8'hFF;
        mq = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
        rxq = '{{9'd0, 8'h5A}, {9'd1, 8'hC3}, {9'd2, 8'hFF}, {9'd3, 8'h00}};
        sq = '{8'h5A, 8'hC3, 8'hFF, 8'h00};
        prime();
        run(16'hC003, 200, -1);
        chk("exch_done_cycle", r_cyc, 72);
        chk("exch_busy_cycles", r_busy, 72);
        chk("exch_first_rise", r_clk1, 3);
        chk("exch_cs_during", r_csbad, 0);
        chk("exch_status", Status, 16'h4003);
        chk("exch_done_1cyc", Done, 0);
        chk("exch_idle_do", SPI_Do, 1);
        chk("exch_rxq_empty", rxq.size(), 0);

        // TX-only, 512 bytes
        for (int i = 0; i < 512; i++) begin
            tx_mem[i] = 8'(i * 7 + 3);
            mq.push_back(8'(i * 7 + 3));
        end
        prime();
        run(16'hC3FF, 10000, -1);
        chk("txo_done_cycle", r_cyc, 9216);
        chk("txo_busy_cycles", r_busy, 9216);
        chk("txo_max_addr", r_maxa, 32'h1FF);
        chk("txo_status", Status, 16'h43FF);
        chk("txo_mq_empty", mq.size(), 0);

        // slow clock, single byte
        mq.push_back(tx_mem[0]);
        rxq.push_back({9'd0, 8'h96});
        sq.push_back(8'h96);
        prime();
        run(16'hC800, 400, -1);
        chk("slow_busy_cycles", r_busy, 258);
        chk("slow_high_len", r_hi, 16);
        chk("slow_period", r_per, 32);
        chk("slow_cs_during", r_csbad, 0);
        chk("slow_cs_after", SPI_Cs, 0);
        chk("slow_status", Status, 16'h4800);

        // CntWrite while busy must be ignored
        tx_mem[0] = 8'h81; tx_mem[1] = 8'h7E;
        mq.push_back(8'h81); mq.push_back(8'h7E);
        rxq.push_back({9'd0, 8'h12}); rxq.push_back({9'd1, 8'h34});
        sq.push_back(8'h12); sq.push_back(8'h34);
        prime();
        run(16'hC001, 200, 10);
        chk("intf_done_cycle", r_cyc, 36);
        chk("intf_cs_during", r_csbad, 0);
        chk("intf_cs_after", SPI_Cs, 0);
        chk("intf_status", Status, 16'h4001);

        // mode 11 with a non-FF first byte behaves as RX-only either way
        repeat (3) mq.push_back(8'hFF);
        rxq = '{{9'd0, 8'hFE}, {9'd1, 8'h11}, {9'd2, 8'h22}};
        sq = '{8'hFE, 8'h11, 8'h22};
        prime();
        run(16'hC602, 200, -1);
        chk("m11_done_cycle", r_cyc, 54);
        chk("m11_status", Status, 16'h4602);

`ifdef SPI_WAIT_TOKEN_EN
        repeat (5) mq.push_back(8'hFF);
        rxq = '{{9'd0, 8'hFE}, {9'd1, 8'h11}, {9'd2, 8'h22}};
        sq = '{8'hFF, 8'hFF, 8'hFE, 8'h11, 8'h22};
        prime();
        run(16'hC602, 300, -1);
        chk("tok_done_cycle", r_cyc, 90);
        chk("tok_status", Status, 16'h4602);

        repeat (1024) mq.push_back(8'hFF);
        prime();
        run(16'hC600, 20000, -1);
        chk("tmo_done_cycle", r_cyc, 18432);
        chk("tmo_status", Status, 16'h5600);
        CntData = 16'h4000;
        CntWrite = 1'b1;
        @(posedge FastClk);
        #1;
        CntWrite = 1'b0;
        chk("tmo_cleared", Status, 16'h4000);
`else
        mq = '{8'hFF, 8'hFF, 8'hFF};
        rxq = '{{9'd0, 8'hFF}, {9'd1, 8'h11}, {9'd2, 8'h22}};
        sq = '{8'hFF, 8'h11, 8'h22};
        prime();
        run(16'hC602, 200, -1);
        chk("m11ff_done_cycle", r_cyc, 54);
        chk("m11ff_status", Status, 16'h4602);
`endif
        chk("rxq_empty", rxq.size(), 0);
        chk("mq_empty", mq.size(), 0);

        // reset in the middle of a TX-only transfer
        mq.push_back(tx_mem[0]);
        CntData = 16'hC203;
        CntWrite = 1'b1;
        @(posedge FastClk);
        #1;
        CntWrite = 1'b0;
        repeat (20) @(posedge FastClk);
        #1;
        chk("mid_busy", Busy, 1);
        nReset = 1'b0;
        @(posedge FastClk);
        #1;
        chk("mid_rst_cs", SPI_Cs, 1);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_clk", SPI_Clk, 0);
        chk("mid_rst_do", SPI_Do, 1);
        chk("mid_rst_status", Status, 16'h0000);
        chk("mid_mq_empty", mq.size(), 0);
        nReset = 1'b1;
        repeat (2) @(posedge FastClk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Sequences multi-byte SPI transfers to the TF card on the cartridge's FastClk domain. A single control-register write starts the block. It walks the 512-byte TX buffer, shifts each byte out MSB-first in SPI mode 0, and writes the received bytes into the 512-byte RX buffer. It sits between the SPI_CNT register decode and the TX/RX block RAMs, and it is the sole driver of SPI_Clk, SPI_Do and SPI_Cs.

## Interface
Parameters:
- SLOW_HALF, 16: FastClk cycles per SPI clock half-period in slow mode (card init). Must be ≥2.
- TOKEN_TIMEOUT, 1024: maximum number of 0xFF bytes clocked while waiting for a token.

Ports:
- FastClk  in  1  sole clock. All logic is on its rising edge.
- nReset  in  1  reset, synchronous and active-low.
- CntWrite  in  1  one-cycle pulse that loads CntData.
- CntData  in  16  bit fields:
  - [8:0] length−1
  - [10:9] mode: 00 exchange, 01 TX-only, 10 RX-only, 11 wait-token
  - [11] slow clock
  - [14] chip-select assert
  - [15] start
- Status  out  16  [8:0] length−1, [10:9] mode, [11] slow, [12] timeout, [13] 0, [14] CS, [15] Busy.
- Busy  out  1  transfer in progress.
- Done  out  1  one-cycle pulse at transfer end.
- TXAddr  out  9  TX buffer read address. The buffer has synchronous read, so data arrives on the next cycle.
- TXData  in  8  TX buffer read data.
- RXAddr  out  9  RX buffer write address.
- RXData  out  8  RX buffer write data.
- RXWrite  out  1  RX buffer write strobe, one cycle.
- SPI_Clk  out  1  SPI clock. Idles low.
- SPI_Do  out  1  MOSI. Idles 1.
- SPI_Di  in  1  MISO.
- SPI_Cs  out  1  chip select, active low.

## Operation
- Reset values:
  - Busy=0, Done=0, RXWrite=0.
  - SPI_Clk=0, SPI_Do=1, SPI_Cs=1.
  - All Status fields 0.
  - Byte index 0, FSM in IDLE.
- Register load: CntWrite while IDLE loads length, mode, slow and CS.
  - SPI_Cs follows ~CS from the next cycle.
  - If start=1, the block also enters FETCH and Busy rises on the next cycle.
  - Any new load clears timeout.
- CntWrite while Busy is ignored in full, including CS.
- FSM states: IDLE → FETCH → SHIFT (8 bits, each bit a low phase then a high phase) → STORE → FETCH or DONE → IDLE.
- FETCH: drive TXAddr = index.
- Outgoing byte, latched on the cycle after FETCH:
  - TXData in exchange and TX-only modes.
  - 0xFF in RX-only and wait-token modes.
- SHIFT:
  - SPI_Do is set up at the start of the low phase.
  - SPI_Di is sampled on the cycle SPI_Clk rises.
  - Bit order is MSB first.
- STORE:
  - RXWrite=1 with RXAddr = index, except in TX-only mode, which never writes.
  - If index == length, go to DONE. Otherwise increment index and go to FETCH.
- DONE: Done=1 and Busy=0 in the same cycle, then IDLE. SPI_Do returns to 1 and SPI_Clk stays 0.
- Index width is 9 bits. Length−1 = 0 gives 1 byte; 511 gives 512 bytes. The index never wraps.
- Wait-token mode (with the macro, below):
  - Received bytes equal to 0xFF are discarded: no RXWrite and no index advance.
  - The first non-0xFF byte is stored at RX[0]. The remaining length bytes then proceed as RX-only.
  - After TOKEN_TIMEOUT discarded bytes: set timeout, write nothing, go to DONE.
- Reset mid-transfer: return to IDLE immediately with reset values. SPI_Cs deasserts. Partial RX contents are undefined.

## Timing
- Bit period: 2 FastClk cycles in fast mode; 2×SLOW_HALF cycles in slow mode.
- Byte period: 16 + 2 cycles in fast mode (FETCH, 8×2 SHIFT, STORE). N bytes take 18N cycles.
- Latency:
  - CntWrite(start) to Busy=1: 1 cycle.
  - CntWrite(start) to first SPI_Clk rise: 3 cycles in fast mode.
  - Last STORE to Done: 1 cycle.
- SPI_Cs changes only in IDLE, so it is stable during the whole transfer.

## Configuration
- SPI_WAIT_TOKEN_EN:
  - Defined: wait-token mode and the timeout counter are built as described.
  - Undefined: mode 11 behaves exactly as RX-only, the timeout bit reads 0, and the counter is absent.

## Test plan
- Reset: hold nReset=0 for 2 cycles → SPI_Cs=1, SPI_Do=1, SPI_Clk=0, Status=0x0000.
- Exchange: TX[0..3] = A5 3C 00 FF, slave echoes the inverted byte, CntData=0xC003 → MOSI carries A5 3C 00 FF MSB-first; RX[0..3] = 5A C3 FF 00; Done pulses at cycle 72 after Busy rise; Status=0x4003 afterwards.
- TX-only 512 bytes, CntData=0xC3FF → no RXWrite; TXAddr reaches 0x1FF and stops; Busy high for exactly 9216 cycles.
- Slow clock, 1 byte, CntData=0xC800 → SPI_Clk high/low phases of 16 cycles each; transfer completes in 258 cycles; CS stays asserted.
- Busy interference: CntWrite 0x0000 during a transfer → SPI_Cs stays 0, length unchanged, transfer completes normally.
- SPI_WAIT_TOKEN_EN defined:
  - Mode 11, length−1 = 2, slave sends FF FF FE 11 22 → RX[0..2] = FE 11 22.
  - All-FF slave → timeout=1 after 1024 bytes; Done pulses with no RXWrite.
